// File: rtl/dca_matrix_rreq_sched_pkg.sv
// Purpose : shared definitions for the matrix-load read-request scheduler and
//           the downstream row-alignment stage (state encodings, txn_info layout).
// Ports   : none (package).
package dca_matrix_rreq_sched_pkg;

    // Scheduler control states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // txn_info = {is_last_row, is_first_row, alen[7:0], bitaddr_offset}
    localparam int TXN_FLAG_W = 2;
    localparam int TXN_ALEN_W = 8;

    // Bit offset into a beat: byte offset (log2 bytes/beat bits) times 8.
    function automatic int txn_off_w(input int bytes_per_beat);
        return $clog2(bytes_per_beat) + 3;
    endfunction

    function automatic int txn_info_w(input int bytes_per_beat);
        return TXN_FLAG_W + TXN_ALEN_W + txn_off_w(bytes_per_beat);
    endfunction

    function automatic int txn_alen_lsb(input int bytes_per_beat);
        return txn_off_w(bytes_per_beat);
    endfunction

    function automatic int txn_first_pos(input int bytes_per_beat);
        return txn_off_w(bytes_per_beat) + TXN_ALEN_W;
    endfunction

    function automatic int txn_last_pos(input int bytes_per_beat);
        return txn_off_w(bytes_per_beat) + TXN_ALEN_W + 1;
    endfunction

endpackage

// File: rtl/dca_matrix_rreq_burst_calc.sv
// Purpose : per-row AXI burst geometry (beat-aligned address, length, bit offset, legality).
// Latency : purely combinational, 0 cycles.
// Backpr. : none; ports are row_addr/num_col_m1 in, araddr/arlen/bitaddr_offset/illegal out.
module dca_matrix_rreq_burst_calc
    import dca_matrix_rreq_sched_pkg::*;
#(
    parameter int BW_ADDR         = 32,
    parameter int BW_AXI_DATA     = 128,
    parameter int ELEM_BYTES      = 4,
    parameter int BW_NUM_M1       = 8,
    parameter int MAX_BURST_BEATS = 16,
    localparam int BYTES_PER_BEAT = BW_AXI_DATA / 8,
    localparam int LSB_W          = $clog2(BYTES_PER_BEAT),
    localparam int OFF_W          = txn_off_w(BYTES_PER_BEAT)
) (
    input  logic [BW_ADDR-1:0]   row_addr,
    input  logic [BW_NUM_M1-1:0] num_col_m1,
    output logic [BW_ADDR-1:0]   araddr,
    output logic [7:0]           arlen,
    output logic [OFF_W-1:0]     bitaddr_offset,
    output logic                 illegal
);

    // Wide enough that off + row_bytes + rounding can never wrap before the limit compare.
    localparam int CALC_W = 32;

    logic [CALC_W-1:0] w_off;
    logic [CALC_W-1:0] w_row_bytes;
    logic [CALC_W-1:0] w_beats;

    assign w_off       = CALC_W'(row_addr[LSB_W-1:0]);
    assign w_row_bytes = (CALC_W'(num_col_m1) + CALC_W'(1)) * CALC_W'(ELEM_BYTES);
    // ceil((off + row_bytes) / BYTES_PER_BEAT); BYTES_PER_BEAT is a power of two.
    assign w_beats     = (w_off + w_row_bytes + CALC_W'(BYTES_PER_BEAT - 1)) >> LSB_W;

    assign araddr         = {row_addr[BW_ADDR-1:LSB_W], {LSB_W{1'b0}}};
    assign arlen          = w_beats[7:0] - 8'd1;
    assign bitaddr_offset = {row_addr[LSB_W-1:0], 3'b000};
    assign illegal        = (w_beats > CALC_W'(MAX_BURST_BEATS));

endmodule

// File: rtl/dca_matrix_rreq_sched.sv
// Purpose : matrix-load read-request scheduler; one AXI AR burst + one txn_info push per row.
// Latency : first AR one cycle after instruction accept, then one row per cycle while credits allow.
// Backpr. : AR held off when credits exhausted or txn FIFO full; instructions wait while busy.
// Ports   : clk/rstnn; inst_* instruction handshake; ar* AXI read address; txn_* alignment FIFO push;
//           rlast_done credit return; busy/done/error status.
// Option  : DCA_MATRIX_RREQ_SCHED_STATS_EN adds stat_burst_cnt / stat_stall_cnt outputs.
module dca_matrix_rreq_sched
    import dca_matrix_rreq_sched_pkg::*;
#(
    parameter int BW_ADDR         = 32,
    parameter int BW_AXI_DATA     = 128,
    parameter int ELEM_BYTES      = 4,
    parameter int BW_NUM_M1       = 8,
    parameter int BW_STRIDE_LS3   = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int MAX_BURST_BEATS = 16,
    localparam int BYTES_PER_BEAT = BW_AXI_DATA / 8,
    localparam int BW_TXN_INFO    = txn_info_w(BYTES_PER_BEAT)
) (
    input  logic                     clk,
    input  logic                     rstnn,
    input  logic                     inst_valid,
    output logic                     inst_ready,
    input  logic [BW_ADDR-1:0]       inst_addr,
    input  logic [BW_STRIDE_LS3-1:0] inst_stride_ls3,
    input  logic [BW_NUM_M1-1:0]     inst_num_row_m1,
    input  logic [BW_NUM_M1-1:0]     inst_num_col_m1,
    output logic [BW_ADDR-1:0]       araddr,
    output logic [7:0]               arlen,
    output logic                     arvalid,
    input  logic                     arready,
    output logic                     txn_valid,
    input  logic                     txn_ready,
    output logic [BW_TXN_INFO-1:0]   txn_info,
    input  logic                     rlast_done,
`ifdef DCA_MATRIX_RREQ_SCHED_STATS_EN
    output logic [31:0]              stat_burst_cnt,
    output logic [31:0]              stat_stall_cnt,
`endif
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    localparam int OFF_W = txn_off_w(BYTES_PER_BEAT);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    state_e                   r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic [BW_ADDR-1:0]       r_row_addr;
    logic [BW_STRIDE_LS3-1:0] r_stride_ls3;
    logic [BW_NUM_M1-1:0]     r_num_row_m1;
    logic [BW_NUM_M1-1:0]     r_num_col_m1;
    logic [BW_NUM_M1-1:0]     r_row_cnt;
    logic                     r_done;
    logic                     r_error;

    logic [BW_ADDR-1:0]       w_araddr;
    logic [7:0]               w_arlen;
    logic [OFF_W-1:0]         w_off;
    logic                     w_illegal;
    logic                     w_hs;
    logic                     w_dec;
    logic                     w_first;
    logic                     w_last;

    dca_matrix_rreq_burst_calc #(
        .BW_ADDR         (BW_ADDR),
        .BW_AXI_DATA     (BW_AXI_DATA),
        .ELEM_BYTES      (ELEM_BYTES),
        .BW_NUM_M1       (BW_NUM_M1),
        .MAX_BURST_BEATS (MAX_BURST_BEATS)
    ) u_burst_calc (
        .row_addr       (r_row_addr),
        .num_col_m1     (r_num_col_m1),
        .araddr         (w_araddr),
        .arlen          (w_arlen),
        .bitaddr_offset (w_off),
        .illegal        (w_illegal)
    );

    // arvalid depends only on registered state and txn_ready, never on arready;
    // the payload comes from r_row_addr, which moves only on a handshake.
    assign arvalid   = (r_state == ST_ISSUE) && (r_cnt < CNT_W'(MAX_OUTSTANDING))
                       && txn_ready && !w_illegal;
    assign w_hs      = arvalid && arready;
    assign txn_valid = w_hs;
    // A credit return with nothing outstanding is dropped.
    assign w_dec     = rlast_done && (r_cnt != '0);

    assign w_first  = (r_row_cnt == '0);
    assign w_last   = (r_row_cnt == r_num_row_m1);
    assign araddr   = w_araddr;
    assign arlen    = w_arlen;
    assign txn_info = {w_last, w_first, w_arlen, w_off};

    assign inst_ready = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign error      = r_error;

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_row_addr   <= '0;
            r_stride_ls3 <= '0;
            r_num_row_m1 <= '0;
            r_num_col_m1 <= '0;
            r_row_cnt    <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_hs && !w_dec) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_dec && !w_hs) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (inst_valid) begin
                        r_row_addr   <= inst_addr;
                        r_stride_ls3 <= inst_stride_ls3;
                        r_num_row_m1 <= inst_num_row_m1;
                        r_num_col_m1 <= inst_num_col_m1;
                        r_row_cnt    <= '0;
                        r_error      <= 1'b0;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_illegal) begin
                        // Abort the instruction; bursts already issued still drain.
                        r_error <= 1'b1;
                        r_state <= ST_DRAIN;
                    end else if (w_hs) begin
                        r_row_addr <= r_row_addr + (BW_ADDR'(r_stride_ls3) << 3);
                        r_row_cnt  <= r_row_cnt + BW_NUM_M1'(1);
                        if (w_last) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == '0) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef DCA_MATRIX_RREQ_SCHED_STATS_EN
    logic [31:0] r_stat_burst_cnt;
    logic [31:0] r_stat_stall_cnt;

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_stat_burst_cnt <= '0;
            r_stat_stall_cnt <= '0;
        end else if (r_state == ST_IDLE && inst_valid) begin
            r_stat_burst_cnt <= '0;
            r_stat_stall_cnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            if (w_hs) begin
                if (r_stat_burst_cnt != '1) r_stat_burst_cnt <= r_stat_burst_cnt + 32'd1;
            end else begin
                if (r_stat_stall_cnt != '1) r_stat_stall_cnt <= r_stat_stall_cnt + 32'd1;
            end
        end
    end

    assign stat_burst_cnt = r_stat_burst_cnt;
    assign stat_stall_cnt = r_stat_stall_cnt;
`endif

endmodule

// File: tb/tb_dca_matrix_rreq_sched.sv
module tb_dca_matrix_rreq_sched;

    logic        clk;
    logic        rstnn;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_addr;
    logic [15:0] inst_stride_ls3;
    logic [7:0]  inst_num_row_m1;
    logic [7:0]  inst_num_col_m1;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic        txn_valid;
    logic        txn_ready;
    logic [16:0] txn_info;
    logic        rlast_done;
    logic        busy;
    logic        done;
    logic        error;

    int tests_run = 0;
    int tests_failed = 0;
    int hs;

    dca_matrix_rreq_sched dut (
        .clk             (clk),
        .rstnn           (rstnn),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_addr       (inst_addr),
        .inst_stride_ls3 (inst_stride_ls3),
        .inst_num_row_m1 (inst_num_row_m1),
        .inst_num_col_m1 (inst_num_col_m1),
        .araddr          (araddr),
        .arlen           (arlen),
        .arvalid         (arvalid),
        .arready         (arready),
        .txn_valid       (txn_valid),
        .txn_ready       (txn_ready),
        .txn_info        (txn_info),
        .rlast_done      (rlast_done),
        .busy            (busy),
        .done            (done),
        .error           (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [31:0] a, input logic [15:0] s,
                         input logic [7:0] r, input logic [7:0] c);
        inst_valid      = 1'b1;
        inst_addr       = a;
        inst_stride_ls3 = s;
        inst_num_row_m1 = r;
        inst_num_col_m1 = c;
        @(negedge clk);
        inst_valid = 1'b0;
    endtask

    // Return n credits one per cycle; done must appear exactly one cycle after the last.
    task automatic drain(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            rlast_done = 1'b1;
            @(negedge clk);
            chk({tag, "_done_early"}, {31'd0, done}, 32'd0);
        end
        rlast_done = 1'b0;
        @(negedge clk);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_idle"}, {31'd0, inst_ready}, 32'd1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    task automatic run_case1(input string tag);
        issue(32'h1000, 16'd2, 8'd2, 8'd3);
        chk({tag, "_r0_vld"},  {31'd0, arvalid}, 32'd1);
        chk({tag, "_r0_txn"},  {31'd0, txn_valid}, 32'd1);
        chk({tag, "_r0_addr"}, araddr, 32'h1000);
        chk({tag, "_r0_len"},  {24'd0, arlen}, 32'd0);
        chk({tag, "_r0_info"}, {15'd0, txn_info}, 32'h08000);
        @(negedge clk);
        chk({tag, "_r1_addr"}, araddr, 32'h1010);
        chk({tag, "_r1_info"}, {15'd0, txn_info}, 32'h00000);
        @(negedge clk);
        chk({tag, "_r2_addr"}, araddr, 32'h1020);
        chk({tag, "_r2_info"}, {15'd0, txn_info}, 32'h10000);
        @(negedge clk);
        chk({tag, "_drain_vld"},  {31'd0, arvalid}, 32'd0);
        chk({tag, "_drain_busy"}, {31'd0, busy}, 32'd1);
        drain(3, tag);
    endtask

    initial begin
        rstnn = 1'b0; inst_valid = 1'b0; inst_addr = '0; inst_stride_ls3 = '0;
        inst_num_row_m1 = '0; inst_num_col_m1 = '0;
        arready = 1'b1; txn_ready = 1'b1; rlast_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // Reset state
        chk("rst_inst_ready", {31'd0, inst_ready}, 32'd1);
        chk("rst_arvalid",    {31'd0, arvalid}, 32'd0);
        chk("rst_txn_valid",  {31'd0, txn_valid}, 32'd0);
        chk("rst_busy",       {31'd0, busy}, 32'd0);
        chk("rst_done",       {31'd0, done}, 32'd0);
        chk("rst_error",      {31'd0, error}, 32'd0);
        rstnn = 1'b1;
        @(negedge clk);

        // Case 1: three aligned rows, stride 16 B
        run_case1("c1");

        // Case 2: unaligned single row, 4 B offset spills into a second beat
        issue(32'h1004, 16'd0, 8'd0, 8'd3);
        chk("c2_addr", araddr, 32'h1000);
        chk("c2_len",  {24'd0, arlen}, 32'd1);
        chk("c2_info", {15'd0, txn_info}, 32'h180A0);
        @(negedge clk);
        drain(1, "c2");

        // Case 3: credit limit of 4 with no returns
        issue(32'h2000, 16'd2, 8'd5, 8'd3);
        hs = 0;
        for (int i = 0; i < 8; i++) begin
            hs += int'(arvalid);
            @(negedge clk);
        end
        chk("c3_hs_count", hs, 32'd4);
        chk("c3_stall_vld", {31'd0, arvalid}, 32'd0);
        chk("c3_stall_addr", araddr, 32'h2040);
        rlast_done = 1'b1;
        @(negedge clk);
        rlast_done = 1'b0;
        #1;
        chk("c3_credit_vld",  {31'd0, arvalid}, 32'd1);
        chk("c3_credit_addr", araddr, 32'h2040);
        @(negedge clk);
        chk("c3_full_again", {31'd0, arvalid}, 32'd0);
        chk("c3_next_addr", araddr, 32'h2050);

        // Case 4: bring count to 2, then txn FIFO full, then coincident return + handshake
        rlast_done = 1'b1;
        arready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rlast_done = 1'b0;
        #1;
        chk("c4_vld_cnt2", {31'd0, arvalid}, 32'd1);
        txn_ready = 1'b0;
        #1;
        chk("c4_full_vld",  {31'd0, arvalid}, 32'd0);
        chk("c4_full_txn",  {31'd0, txn_valid}, 32'd0);
        chk("c4_full_addr", araddr, 32'h2050);
        txn_ready = 1'b1;
        arready = 1'b1;
        rlast_done = 1'b1;
        #1;
        chk("c4_hs_vld",  {31'd0, txn_valid}, 32'd1);
        chk("c4_hs_info", {15'd0, txn_info}, 32'h10000);
        @(negedge clk);
        rlast_done = 1'b0;
        chk("c4_drain_vld", {31'd0, arvalid}, 32'd0);
        drain(2, "c4");

        // Case 5: 512 B row is illegal; error sticky until next accept
        issue(32'h3000, 16'd0, 8'd0, 8'd127);
        chk("c5_no_ar", {31'd0, arvalid}, 32'd0);
        chk("c5_no_txn", {31'd0, txn_valid}, 32'd0);
        @(negedge clk);
        chk("c5_error", {31'd0, error}, 32'd1);
        chk("c5_done_early", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("c5_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        chk("c5_done_pulse", {31'd0, done}, 32'd0);
        chk("c5_error_sticky", {31'd0, error}, 32'd1);

        // Largest legal burst: 256 B aligned = 16 beats; accept clears error
        issue(32'h4000, 16'd0, 8'd0, 8'd63);
        chk("c5_err_clear", {31'd0, error}, 32'd0);
        chk("max_vld", {31'd0, arvalid}, 32'd1);
        chk("max_len", {24'd0, arlen}, 32'd15);
        chk("max_info", {15'd0, txn_info}, 32'h18780);
        @(negedge clk);
        drain(1, "max");

        // Same row 4 B off alignment needs 17 beats -> illegal
        issue(32'h4004, 16'd0, 8'd0, 8'd63);
        chk("max1_no_ar", {31'd0, arvalid}, 32'd0);
        @(negedge clk);
        chk("max1_error", {31'd0, error}, 32'd1);
        @(negedge clk);
        chk("max1_done", {31'd0, done}, 32'd1);
        @(negedge clk);

        // Case 6: reset in ISSUE after one AR
        issue(32'h1000, 16'd2, 8'd2, 8'd3);
        @(negedge clk);
        rstnn = 1'b0;
        #1;
        chk("c6_arvalid", {31'd0, arvalid}, 32'd0);
        chk("c6_busy", {31'd0, busy}, 32'd0);
        chk("c6_inst_ready", {31'd0, inst_ready}, 32'd1);
        @(negedge clk);
        rstnn = 1'b1;
        @(negedge clk);
        run_case1("c6");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
